// File: rtl/result_bcd_display.sv
// -----------------------------------------------------------------------------
// result_bcd_display
//   Sequential binary-to-BCD converter (double dabble, one shift per clock)
//   with a seven-segment encoder for the calculator result.
//
//   Optional feature macro: BCD_SIGNED_EN
//     When defined, resultado is two's complement. The magnitude is converted
//     and neg reports the sign. When undefined, neg is tied to 0.
//
//   Parameters
//     N       calculator operand width (input is 2N bits)
//     DIGITS  number of BCD digits (10^DIGITS > 2^(2N))
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     start      convert request, sampled only in IDLE
//     resultado  2N-bit result word to display
//     busy       high while a conversion is in progress
//     done       one-cycle pulse when bcd/seg/neg carry a new value
//     neg        sign flag (BCD_SIGNED_EN only)
//     bcd        digit k at bcd[4k+3:4k], k=0 is ones
//     seg        active-low {g,f,e,d,c,b,a} per digit, digit k at seg[7k+6:7k]
// -----------------------------------------------------------------------------
module result_bcd_display #(
    parameter int N      = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*N-1:0]        resultado,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int VW = 2 * N;
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + VW;
    localparam int CW = $clog2(2 * N + 1);

    localparam logic [7*DIGITS-1:0] SEG_ZEROS = {DIGITS{7'b1000000}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [SW-1:0]       r_sr;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    logic [BW-1:0]       r_bcd;
    logic [7*DIGITS-1:0] r_seg;

    logic [SW-1:0]       w_adj;
    logic [7*DIGITS-1:0] w_seg;
    logic [VW-1:0]       w_value;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Binary field passes through untouched; each BCD nibble gets its +3
    // correction before the shift so it carries correctly into the next digit.
    assign w_adj[VW-1:0] = r_sr[VW-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[VW+4*gi +: 4] = (r_sr[VW+4*gi +: 4] >= 4'd5)
                                       ? r_sr[VW+4*gi +: 4] + 4'd3
                                       : r_sr[VW+4*gi +: 4];
            assign w_seg[7*gi +: 7] = seg7(r_sr[VW+4*gi +: 4]);
        end
    endgenerate

`ifdef BCD_SIGNED_EN
    logic r_sign;
    logic r_neg;

    // Negating in VW bits makes -2^(VW-1) map to its own bit pattern, which
    // is exactly the unsigned magnitude 2^(VW-1).
    assign w_value = resultado[VW-1] ? VW'(-resultado) : resultado;
    assign neg     = r_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start)
                r_sign <= resultado[VW-1];
            if (r_state == S_DONE)
                r_neg <= r_sign;
        end
    end
`else
    assign w_value = resultado;
    assign neg     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_seg   <= SEG_ZEROS;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= {{BW{1'b0}}, w_value};
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= {w_adj[SW-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(2 * N - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd   <= r_sr[SW-1:VW];
                    r_seg   <= w_seg;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign seg  = r_seg;

endmodule

// File: tb/tb_result_bcd_display.sv
module tb_result_bcd_display;

    localparam int N      = 4;
    localparam int DIGITS = 3;
    localparam int VW     = 2 * N;
    localparam int LAT    = 2 * N + 1;
    localparam logic [20:0] SEG0 = {3{7'b1000000}};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [VW-1:0]     resultado = '0;
    logic              busy, done, neg;
    logic [11:0]       bcd;
    logic [20:0]       seg;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;
    int nbusy  = 0;

    result_bcd_display #(.N(N), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .resultado(resultado),
        .busy(busy), .done(done), .neg(neg), .bcd(bcd), .seg(seg)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [0:9];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    end

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [20:0] to_seg(input int v);
        logic [20:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[7*k +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int magnitude(input logic [VW-1:0] v);
`ifdef BCD_SIGNED_EN
        if (v[VW-1]) return (1 << VW) - int'(v);
`endif
        return int'(v);
    endfunction

    function automatic logic is_neg(input logic [VW-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[VW-1];
`else
        return 1'b0;
`endif
    endfunction

    // m_phase counts clocks since the accepted start; 0 means idle.
    int          m_phase;
    int          m_mag;
    logic        m_sgn;
    logic        e_done, e_neg;
    logic [11:0] e_bcd;
    logic [20:0] e_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_mag <= 0; m_sgn <= 1'b0;
            e_done <= 1'b0; e_neg <= 1'b0; e_bcd <= '0; e_seg <= SEG0;
        end else if (m_phase == 0) begin
            e_done <= 1'b0;
            if (start) begin
                m_mag   <= magnitude(resultado);
                m_sgn   <= is_neg(resultado);
                m_phase <= 1;
            end
        end else if (m_phase == LAT) begin
            e_done  <= 1'b1;
            e_bcd   <= to_bcd(m_mag);
            e_seg   <= to_seg(m_mag);
            e_neg   <= m_sgn;
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("bcd",  32'(bcd),  32'(e_bcd));
        chk("seg",  32'(seg),  32'(e_seg));
        chk("neg",  32'(neg),  32'(e_neg));
        if (done) ndone++;
        if (busy) nbusy++;
    end

    // Call just after a negedge. Pulses start for one edge, waits for done.
    task automatic run(input logic [VW-1:0] v, input logic [11:0] exp_bcd, input string name);
        int n;
        resultado = v;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 30) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, LAT);
        end
        chk({name, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        $display("conv %s: resultado=%0d bcd=%h seg=%b neg=%0d", name, v, bcd, seg, neg);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_bcd", 32'(bcd), 32'h000);
        chk("reset_seg", 32'(seg), 32'(SEG0));

        // zero
        run(8'd0, 12'h000, "zero");
        chk("zero_seg", 32'(seg), 32'(SEG0));

        // 255, busy length
        nbusy = 0;
        run(8'd255, 12'h255, "v255");
        chk("v255_seg", 32'(seg), 32'({7'b0100100, 7'b0010010, 7'b0010010}));
        repeat (2) @(negedge clk);
        chk("v255_busy_cycles", 32'(nbusy), 32'd9);

        // start re-pulsed during busy with changed input
        ndone = 0;
        resultado = 8'd123; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 resultado = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignore_bcd", 32'(bcd), 32'h123);
        chk("ignore_ndone", 32'(ndone), 32'd1);
        $display("conv ignore: bcd=%h done_pulses=%0d", bcd, ndone);

        // reset mid-conversion
        ndone = 0;
        @(negedge clk);
        resultado = 8'd200; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_bcd", 32'(bcd), 32'h000);
        chk("abort_seg", 32'(seg), 32'(SEG0));
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_ndone", 32'(ndone), 32'd0);
        $display("conv abort: bcd=%h done_pulses=%0d", bcd, ndone);
        run(8'd42, 12'h042, "v42");

        // back-to-back: second start lands at t0+10
        @(negedge clk);
        ndone = 0;
        run(8'd99, 12'h099, "v99");
        run(8'd100, 12'h100, "v100");
        repeat (2) @(negedge clk);
        chk("b2b_ndone", 32'(ndone), 32'd2);

        // sign handling
`ifdef BCD_SIGNED_EN
        run(8'hF6, 12'h010, "vF6");
        chk("vF6_neg", 32'(neg), 32'd1);
        run(8'h80, 12'h128, "v80");
        chk("v80_neg", 32'(neg), 32'd1);
        run(8'h7F, 12'h127, "v7F");
        chk("v7F_neg", 32'(neg), 32'd0);
`else
        run(8'hF6, 12'h246, "vF6");
        chk("vF6_neg", 32'(neg), 32'd0);
        run(8'h80, 12'h128, "v80");
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_bcd_display.md
# result_bcd_display

Sequential binary-to-BCD converter and seven-segment encoder that consumes the 2N-bit `resultado` word produced by the calculator datapath and renders it on the board's seven-segment displays. On a `start` pulse it captures the result and runs an iterative double-dabble conversion, one shift per clock. It then registers decimal digits and active-low segment patterns and pulses `done`. It sits between the calculator output and the display pins.

## Interface
- `N`, default 4: calculator operand width; the input result is 2N bits.
- `DIGITS`, default 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^(2N); 3 for N=4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: convert request, sampled only in IDLE.
- `resultado`  in  2N: calculator result to display.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when new outputs are valid.
- `neg`  out  1: sign flag; only active with `BCD_SIGNED_EN`.
- `bcd`  out  4*DIGITS: digit k is `bcd[4k+3:4k]`; k=0 is ones.
- `seg`  out  7*DIGITS: active-low segments per digit, order {g,f,e,d,c,b,a}; digit k is `seg[7k+6:7k]`.

## Operation
- FSM states:
  - IDLE: if `start`=1, load the shift register with {DIGITS*4 zeros, value}, clear the counter, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1 and increment the counter. After the 2N-th shift, go to DONE.
  - DONE: copy the BCD field to `bcd`, encode each nibble to `seg`, latch `neg`, assert `done`, and go to IDLE.
- `value` = `resultado`, captured at the start edge. Later changes to `resultado` have no effect on a conversion in flight.
- Counter width is $clog2(2N+1).
- Segment patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any nibble above 9 (unreachable) encodes to 1111111, i.e. blank.
- No leading-zero blanking; all DIGITS digits are always shown.
- `bcd`, `seg` and `neg` hold their last converted value until the next DONE.
- `start` while `busy`=1 or in DONE is ignored, not queued.
- `busy` = (state != IDLE).
- `done` is a registered output, high only in the cycle after the DONE-state edge.

## Timing
- Start sampled at edge t0.
- Shift edges are t0+1 … t0+2N.
- Outputs update and `done` rises at edge t0+2N+1; `done` falls at t0+2N+2.
- Total latency from start to done is 2N+1 clocks (9 for N=4).
- `busy` is high from t0 until t0+2N+1.
- A new `start` is accepted at edge t0+2N+2 at the earliest.
- Reset values (asynchronous, immediate): state=IDLE, `busy`=0, `done`=0, `neg`=0, `bcd`=0, every `seg` digit=1000000 (shows "0"), shift register and counter = 0.
- Reset asserted mid-conversion aborts the conversion: no `done` pulse, and outputs go to their reset values. The first `start` sampled after reset deassertion begins a fresh conversion.

## Configuration
- `BCD_SIGNED_EN` defined:
  - `resultado` is treated as two's complement.
  - If bit 2N-1 is set, `value` = −`resultado` (2N-bit magnitude, so −2^(2N-1) converts correctly) and `neg` latches 1 at DONE. Otherwise `neg` latches 0.
  - Latency is unchanged; the negation happens at the load edge.
- `BCD_SIGNED_EN` undefined: the input is unsigned and `neg` is constant 0.

## Test plan
- Reset, then `resultado`=8'd0 with `start` → `done` 9 cycles later, `bcd`=12'h000, all seg=1000000.
- `resultado`=8'd255 → `bcd`=12'h255, seg = {0100100, 0010010, 0010010}, `busy` high exactly 9 cycles.
- `resultado`=8'd123, then `resultado` changed to 8'd7 and `start` re-pulsed during `busy` → result 12'h123 with a single `done` pulse; the second start is ignored.
- Reset asserted at shift 4 of a conversion of 8'd200 → outputs at reset values and no `done`. After release, a new start with 8'd42 gives `bcd`=12'h042.
- Two back-to-back conversions (start at t0 and again at t0+10) of 8'd99 and 8'd100 → `bcd` 12'h099, then 12'h100, with two separate `done` pulses.
- `resultado`=8'hF6: with `BCD_SIGNED_EN`, `neg`=1 and `bcd`=12'h010; without it, `neg`=0 and `bcd`=12'h246. With the macro, 8'h80 gives `neg`=1 and `bcd`=12'h128.
